inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Fetch stage directly upstream of the ROB/decoder issue port. Keeps the PC, issues one
//  word read at a time to the instruction memory port, buffers returned words in a small
//  instruction queue, and presents one instruction per cycle as inst_valid/inst/inst_addr.
//  Stops fetching after control-flow instructions until the ROB redirects via next_pc.
// PARAMETERS
//  PC_RESET  32'h0  PC loaded on reset
//  IQ_DEPTH  4      instruction queue entries; power of 2, >=2
//  IQ_BIT    2      log2(IQ_DEPTH)
// PORTS
//  clk_in          in   1   system clock; one clock domain
//  rst_in          in   1   reset, synchronous, active-low
//  rdy_in          in   1   low = pause: no state update, mem_ready ignored
//  mem_req         out  1   read request, level, held until mem_ready
//  mem_addr        out  32  word address of request (pc)
//  mem_ready       in   1   one-cycle pulse: mem_data valid
//  mem_data        in   32  returned instruction word
//  stall_in        in   1   downstream (rob_full etc.) cannot accept this cycle
//  redirect_valid  in   1   ROB pc_frozen/clear_up resolution pulse
//  redirect_pc     in   32  new fetch PC (ROB next_pc)
//  inst_valid      out  1   registered, one pulse per delivered instruction
//  inst            out  32  instruction word
//  inst_addr       out  32  its PC
//  fetch_held      out  1   1 while in HOLD (debug/perf)
// BEHAVIOUR
//  Reset (rst_in==0 at posedge): pc<=PC_RESET; queue empty; state IDLE; drop<=0;
//   mem_req, inst_valid, fetch_held <=0; mem_addr, inst, inst_addr <=0.
//  FSM IDLE: if !hold_pending && count+1<=IQ_DEPTH: mem_req<=1, mem_addr<=pc, -> WAIT.
//  WAIT: on mem_ready: mem_req<=0; if drop: discard word, drop<=0, -> IDLE;
//   else push {pc,mem_data}; pc<=pc+4; predecode opcode mem_data[6:0]:
//   B-type(1100011), JALR(1100111) -> HOLD; JAL(1101111) -> HOLD (see CONFIGURATION);
//   otherwise -> IDLE. Exactly one outstanding request; no request issued from WAIT.
//  HOLD: no requests; fetch_held=1; leave only on redirect_valid.
//  Redirect (highest priority, any state): queue flushed (count<=0), inst_valid<=0,
//   pc<=redirect_pc; IDLE/HOLD -> IDLE; WAIT with mem_ready same cycle -> word discarded,
//   mem_req<=0, -> IDLE; WAIT without mem_ready -> drop<=1, stay WAIT (request completes
//   to old address, discarded). Next request earliest cycle after redirect.
//  Output: each cycle, if !stall_in && count!=0 (post-flush): pop head -> inst_valid<=1,
//   inst/inst_addr<=head; else inst_valid<=0. Latency mem_ready -> inst_valid >=1 cycle
//   (push cycle N, pop visible N+1 earliest). Push and pop same cycle allowed; count unchanged.
//  Full: request gated so queue never overflows; full queue simply stops new requests.
//  Pointers IQ_BIT wide, wrap modulo IQ_DEPTH; count is IQ_BIT+1 wide.
//  pc+4 wraps mod 2^32; PC bits[1:0] never checked.
//  rdy_in low: every register holds; outputs hold values (inst_valid held low).
// CONFIGURATION
//  IFETCH_JAL_PREDICT_EN defined: on JAL, pc<=pc+sext({imm[20:1],0}) from J-immediate,
//   -> IDLE (no HOLD); ROB redirect for JAL still honoured if it arrives.
//  Undefined: JAL enters HOLD like JALR/B-type.
// STRUCTURE
//  Shared package/header: opcode constants (B_TYPE, JAL, JALR), FSM state encodings,
//   PC_RESET default. Sub-module: inst_queue (parameterised FIFO with flush, push, pop,
//   count); FSM, predecode and PC logic stay in inst_fetch.
// TESTING
//  Reset, 3 ALU words at 0x0/0x4/0x8, mem_ready 2 cycles after req -> inst_addr 0,4,8 in order.
//  stall_in held 10 cycles -> queue fills to IQ_DEPTH, mem_req stays 0, no word lost after release.
//  Word 0x00000063 (beq) at 0x10 -> HOLD, no mem_req; redirect_pc=0x40 -> next mem_addr=0x40.
//  Redirect to 0x80 during WAIT, mem_ready 3 cycles later -> returned word dropped, next req 0x80.
//  JAL 0x0080006F at 0x20: macro on -> next mem_addr 0x28; macro off -> HOLD until redirect.
//  rdy_in low 5 cycles mid-WAIT -> pc, count, outputs unchanged; resume completes normally.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_pkg
// Shared definitions for the fetch stage: RV32 control-flow opcodes used by
// the predecoder, the fetch FSM state encoding, the default reset PC and the
// J-type immediate extractor used when JAL prediction is built in.
// -----------------------------------------------------------------------------
package inst_fetch_pkg;

    localparam logic [31:0] IF_PC_RESET = 32'h0000_0000;

    localparam logic [6:0] OPC_B_TYPE = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // free to issue the next read
        ST_WAIT = 2'd1,   // one read outstanding
        ST_HOLD = 2'd2    // control flow seen, waiting for a redirect
    } fetch_state_e;

    // Sign-extended J-type immediate {imm[20:1], 0}.
    function automatic logic [31:0] j_imm(input logic [31:0] w);
        return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/inst_fetch_inst_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_inst_queue
// Small FIFO holding fetched {pc, word} pairs between the memory port and the
// issue port. Head is read combinationally; the consumer registers it.
// Ports:
//   clk_i        clock
//   rst_ni       synchronous active-low reset
//   en_i         low = pause, nothing changes
//   flush_i      empty the queue (dominates push/pop)
//   push_i       write push_data_i at the tail
//   push_data_i  entry to write
//   pop_i        advance the head (caller guarantees count_o != 0)
//   head_o       entry at the head
//   count_o      number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module inst_fetch_inst_queue #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int DATA_W = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic [PTR_W:0]    count_o
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W:0]    count_q;
    logic [PTR_W:0]    count_d;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_i && pop_i) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Storage has no reset so it can map onto RAM primitives.
    always_ff @(posedge clk_i) begin
        if (en_i && push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (en_i) begin
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
                if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
                count_q <= count_d;
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Fetch stage feeding the ROB/decoder issue port. Keeps the PC, issues one
// word read at a time, buffers returned words in a small queue and delivers
// one instruction per cycle. After a branch/JALR (and JAL unless predicted)
// fetching stops until the ROB redirects.
// Build option: define IFETCH_JAL_PREDICT_EN to follow JAL targets locally
// instead of holding.
// Ports:
//   clk_in, rst_in (sync, active-low), rdy_in (low = pause)
//   mem_req/mem_addr -> instruction memory; mem_ready/mem_data <- memory
//   stall_in         downstream cannot accept
//   redirect_valid/redirect_pc  ROB resolved next PC
//   inst_valid/inst/inst_addr   delivered instruction (registered)
//   fetch_held       high while waiting for a redirect
// -----------------------------------------------------------------------------
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = IF_PC_RESET,
    parameter int          IQ_DEPTH = 4,
    parameter int          IQ_BIT   = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_data,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_addr,
    output logic        fetch_held
);

    localparam logic [IQ_BIT:0] IQ_FULL = (IQ_BIT + 1)'(IQ_DEPTH);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         drop_q, drop_d;
    logic         mem_req_q, mem_req_d;
    logic [31:0]  mem_addr_q, mem_addr_d;
    logic         inst_valid_q, inst_valid_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  inst_addr_q, inst_addr_d;

    logic          iq_push, iq_pop, iq_flush;
    logic [63:0]   iq_head;
    logic [IQ_BIT:0] iq_count;

    inst_fetch_inst_queue #(
        .DEPTH  (IQ_DEPTH),
        .PTR_W  (IQ_BIT),
        .DATA_W (64)
    ) u_iq (
        .clk_i       (clk_in),
        .rst_ni      (rst_in),
        .en_i        (rdy_in),
        .flush_i     (iq_flush),
        .push_i      (iq_push),
        .push_data_i ({pc_q, mem_data}),
        .pop_i       (iq_pop),
        .head_o      (iq_head),
        .count_o     (iq_count)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        inst_valid_d = 1'b0;
        inst_d       = inst_q;
        inst_addr_d  = inst_addr_q;
        iq_push      = 1'b0;
        iq_pop       = 1'b0;
        iq_flush     = 1'b0;

        if (redirect_valid) begin
            // Flush wins over everything; nothing is delivered this cycle.
            iq_flush = 1'b1;
            pc_d     = redirect_pc;
            if (state_q == ST_WAIT && !mem_ready) begin
                // The bus request cannot be withdrawn: let it finish and bin it.
                drop_d = 1'b1;
            end else begin
                mem_req_d = 1'b0;
                drop_d    = 1'b0;
                state_d   = ST_IDLE;
            end
        end else begin
            if (!stall_in && iq_count != '0) begin
                iq_pop       = 1'b1;
                inst_valid_d = 1'b1;
                inst_addr_d  = iq_head[63:32];
                inst_d       = iq_head[31:0];
            end

            unique case (state_q)
                ST_IDLE: begin
                    // Only one read is ever in flight, so a free slot now
                    // guarantees room when the word returns.
                    if (iq_count < IQ_FULL) begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_q;
                        state_d    = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_ready) begin
                        mem_req_d = 1'b0;
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = ST_IDLE;
                        end else begin
                            iq_push = 1'b1;
                            pc_d    = pc_q + 32'd4;
                            case (mem_data[6:0])
                                OPC_B_TYPE, OPC_JALR: state_d = ST_HOLD;
                                OPC_JAL: begin
`ifdef IFETCH_JAL_PREDICT_EN
                                    pc_d    = pc_q + j_imm(mem_data);
                                    state_d = ST_IDLE;
`else
                                    state_d = ST_HOLD;
`endif
                                end
                                default: state_d = ST_IDLE;
                            endcase
                        end
                    end
                end
                ST_HOLD: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q      <= ST_IDLE;
            pc_q         <= PC_RESET;
            drop_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_addr_q  <= '0;
        end else if (rdy_in) begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_addr_q  <= inst_addr_d;
        end else begin
            // Paused: keep everything, but never re-present an instruction.
            inst_valid_q <= 1'b0;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_addr  = inst_addr_q;
    assign fetch_held = (state_q == ST_HOLD);

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
// Directed bench for inst_fetch. A behavioural memory answers requests from a
// fixed program image; expected {pc, word} pairs go into a queue and a monitor
// compares every delivered instruction against it.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_data;
    logic        stall_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        fetch_held;

    int checks   = 0;
    int failures = 0;
    int mem_lat  = 2;
    logic [63:0] exp_q [$];

    always #5 clk_in = ~clk_in;

    inst_fetch dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ready      (mem_ready),
        .mem_data       (mem_data),
        .stall_in       (stall_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_addr      (inst_addr),
        .fetch_held     (fetch_held)
    );

    // Program image: beq at 0x10/0x2C/0x5C/0x8C/0x104, JAL +8 at 0x20,
    // everything else "addi" with the address as immediate.
    function automatic logic [31:0] img(input logic [31:0] a);
        case (a)
            32'h10, 32'h2C, 32'h5C, 32'h8C, 32'h104: img = 32'h0000_0063;
            32'h20:                                 img = 32'h0080_006F;
            default:                                img = {a[11:0], 20'h00013};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic expect_inst(input logic [31:0] a);
        exp_q.push_back({a, img(a)});
    endtask

    // Memory model: answers each request after mem_lat cycles and keeps
    // mem_ready up until the DUT actually samples it with rdy_in high.
    initial begin : mem_model
        logic [31:0] req_addr;
        mem_ready = 1'b0;
        mem_data  = '0;
        forever begin
            @(negedge clk_in);
            mem_ready = 1'b0;
            if (rst_in && mem_req) begin
                req_addr = mem_addr;
                repeat (mem_lat - 1) @(negedge clk_in);
                mem_ready = 1'b1;
                mem_data  = img(req_addr);
                do @(posedge clk_in); while (!rdy_in);
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clk_in) begin
        logic [63:0] e;
        if (rst_in === 1'b1 && inst_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_inst actual_addr=%h actual_inst=%h expected=none",
                         inst_addr, inst);
            end else begin
                e = exp_q.pop_front();
                chk("inst_addr", inst_addr, e[63:32]);
                chk("inst_word", inst, e[31:0]);
                $display("deliver addr=%h inst=%h", inst_addr, inst);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // Waits for the next rising edge of mem_req and checks its address.
    task automatic wait_req(input logic [31:0] exp_addr, input string name);
        logic prev;
        bit   seen;
        prev = mem_req;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_in);
            if (mem_req && !prev) begin
                seen = 1;
                chk(name, mem_addr, exp_addr);
            end
            prev = mem_req;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s actual=no_request expected=%h", name, exp_addr);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk_in);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s actual_pending=%0d expected_pending=0", name, exp_q.size());
        end
        tick(3);
    endtask

    task automatic check_hold(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            chk({name, "_held"}, 32'(fetch_held), 32'd1);
            chk({name, "_no_req"}, 32'(mem_req), 32'd0);
        end
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        @(negedge clk_in);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(negedge clk_in);
        redirect_valid = 1'b0;
    endtask

    initial begin : stimulus
        rst_in         = 1'b0;
        rdy_in         = 1'b1;
        stall_in       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset state.
        tick(3);
        chk("rst_mem_req",    32'(mem_req),    32'd0);
        chk("rst_mem_addr",   mem_addr,        32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst",       inst,            32'd0);
        chk("rst_inst_addr",  inst_addr,       32'd0);
        chk("rst_fetch_held", 32'(fetch_held), 32'd0);

        // Sequential ALU words then beq at 0x10 -> HOLD.
        for (int a = 0; a <= 16; a += 4) expect_inst(32'(a));
        rst_in = 1'b1;
        wait_req(32'h0, "first_req");
        wait_drain("drain_seq");
        check_hold(5, "beq_hold");

        // Redirect to 0x40 with downstream stalled: queue fills, fetch stops.
        stall_in = 1'b1;
        do_redirect(32'h40);
        wait_req(32'h40, "redirect_req_40");
        tick(30);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            chk("full_no_req",   32'(mem_req),    32'd0);
            chk("full_no_valid", 32'(inst_valid), 32'd0);
        end
        for (int a = 32'h40; a <= 32'h5C; a += 4) expect_inst(32'(a));
        stall_in = 1'b0;
        wait_drain("drain_after_stall");
        check_hold(2, "beq5c_hold");

        // Redirect while a read is outstanding: the returned word is dropped.
        mem_lat = 6;
        do_redirect(32'h60);
        wait_req(32'h60, "req_60");
        for (int a = 32'h80; a <= 32'h8C; a += 4) expect_inst(32'(a));
        do_redirect(32'h80);
        mem_lat = 2;
        wait_req(32'h80, "req_after_drop");
        wait_drain("drain_after_drop");
        check_hold(2, "beq8c_hold");

        // JAL at 0x20 (target 0x28).
        expect_inst(32'h18);
        expect_inst(32'h1C);
        expect_inst(32'h20);
`ifdef IFETCH_JAL_PREDICT_EN
        expect_inst(32'h28);
        expect_inst(32'h2C);
        do_redirect(32'h18);
        wait_req(32'h18, "jal_req_18");
        wait_req(32'h1C, "jal_req_1c");
        wait_req(32'h20, "jal_req_20");
        wait_req(32'h28, "jal_predicted_req");
        wait_drain("drain_jal");
        check_hold(2, "jal_tail_hold");
`else
        do_redirect(32'h18);
        wait_req(32'h18, "jal_req_18");
        wait_drain("drain_jal");
        check_hold(5, "jal_hold");
        expect_inst(32'h28);
        expect_inst(32'h2C);
        do_redirect(32'h28);
        wait_req(32'h28, "jal_redirect_req");
        wait_drain("drain_jal_redirect");
        check_hold(2, "jal_tail_hold");
`endif

        // Pause mid-WAIT: nothing moves, then the read completes normally.
        mem_lat = 4;
        expect_inst(32'h100);
        expect_inst(32'h104);
        do_redirect(32'h100);
        wait_req(32'h100, "req_100");
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            chk("pause_mem_req",    32'(mem_req),    32'd1);
            chk("pause_mem_addr",   mem_addr,        32'h100);
            chk("pause_inst_valid", 32'(inst_valid), 32'd0);
        end
        rdy_in  = 1'b1;
        mem_lat = 2;
        wait_drain("drain_after_pause");
        check_hold(2, "final_hold");

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
